// File: rtl/mem_access_unit_pkg.sv
// Shared encodings, state enum and request payload for the memory access unit.
package mem_access_unit_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // The reserved size code behaves exactly like a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
    case (eff_size(size))
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~lsb[0];
      default:   return lsb == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load lane select and zero/sign extension of a bus read word.
module load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (eff_size(size_i))
      SIZE_BYTE: data_o = {{24{sext_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data_o = {{16{sext_i & shifted[15]}}, shifted[15:0]};
      default:   data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: alignment check, single bus transfer with timeout,
// load extraction into DR_out.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] DR_out,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic        done
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e         state_q, state_d;
  req_t           req_q, req_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    dr_q, dr_d;
  logic           exc_q, exc_d;
  logic           aligned;
  logic [31:0]    load_data;
  logic [3:0]     be_c;
  logic [31:0]    wdata_c;

  assign aligned = is_aligned(mem_size, addr[1:0]);
  assign DR_out  = dr_q;

  load_ext u_load_ext (
    .rdata_i (bus_rdata),
    .addr_i  (req_q.addr[1:0]),
    .size_i  (req_q.size),
    .sext_i  (req_q.sext),
    .data_o  (load_data)
  );

  // Byte lanes and replicated store data from the latched request.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = req_q.wdata;
    case (eff_size(req_q.size))
      SIZE_BYTE: begin
        be_c    = 4'b0001 << req_q.addr[1:0];
        wdata_c = {4{req_q.wdata[7:0]}};
      end
      SIZE_HALF: begin
        be_c    = 4'b0011 << {req_q.addr[1], 1'b0};
        wdata_c = {2{req_q.wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = req_q.wdata;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    dr_d      = dr_q;
    exc_d     = exc_q;
    stall     = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    done      = 1'b0;
    exc       = 1'b0;
    exc_code  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_valid && !flush) begin
          if (aligned) begin
            stall         = 1'b1;
            req_d.we      = mem_we;
            req_d.size    = mem_size;
            req_d.sext    = mem_sext;
            req_d.addr    = addr;
            req_d.wdata   = wdata;
            cnt_d         = '0;
            state_d       = ST_BUSY;
          end else begin
            exc      = 1'b1;
            exc_code = mem_we ? EXC_ADES : EXC_ADEL;
          end
        end
      end
      ST_BUSY: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = req_q.we;
        bus_addr  = {req_q.addr[31:2], 2'b00};
        bus_be    = be_c;
        bus_wdata = wdata_c;
        // An ack on the last allowed cycle still wins over the timeout.
        if (bus_ack) begin
          exc_d   = 1'b0;
          if (!req_q.we) dr_d = load_data;
          state_d = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          exc_d   = 1'b1;
          dr_d    = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        exc      = exc_q;
        exc_code = exc_q ? EXC_DBE : 5'd0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      dr_q    <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      dr_q    <= dr_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-timeline model plus
// directed literal checks and randomized traffic.
module tb_mem_access_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_we, mem_sext, flush;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        stall, exc, done;
  logic [31:0] DR_out;
  logic [4:0]  exc_code;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_size(mem_size), .mem_sext(mem_sext), .addr(addr), .wdata(wdata),
    .flush(flush), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .stall(stall), .DR_out(DR_out), .exc(exc),
    .exc_code(exc_code), .done(done)
  );

  int checks = 0;
  int errors = 0;

  logic        ev = 1'b0;
  logic        e_stall, e_req, e_we, e_done, e_exc;
  logic [31:0] e_addr, e_wdata, e_dr;
  logic [3:0]  e_be;
  logic [4:0]  e_code;
  logic [31:0] m_dr;

  int          stall_cnt, done_cnt, req_cnt;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [4:0]  cap_code;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference rules for one access.
  function automatic bit m_aligned(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd0) return 1'b1;
    if (size == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
    int unsigned lane = a % 4;
    if (size == 2'd0) return 4'(1 << lane);
    if (size == 2'd1) return (lane >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] size, input logic sext);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (sext && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (sext && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (ev) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("bus_req", 32'(bus_req), 32'(e_req));
      chk("done", 32'(done), 32'(e_done));
      chk("exc", 32'(exc), 32'(e_exc));
      chk("DR_out", DR_out, e_dr);
      if (e_exc) chk("exc_code", 32'(exc_code), 32'(e_code));
      if (e_req) begin
        chk("bus_we", 32'(bus_we), 32'(e_we));
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_be", 32'(bus_be), 32'(e_be));
        chk("bus_wdata", bus_wdata, e_wdata);
      end
      if (stall) stall_cnt++;
      if (done) done_cnt++;
      if (bus_req) begin
        req_cnt++;
        cap_wdata = bus_wdata;
        cap_be    = bus_be;
        cap_we    = bus_we;
      end
      if (exc) cap_code = exc_code;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_stall = 1'b0; e_req = 1'b0; e_done = 1'b0; e_exc = 1'b0;
    e_code = '0; e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
    e_dr = m_dr;
  endtask

  task automatic clear_caps();
    stall_cnt = 0; done_cnt = 0; req_cnt = 0;
    cap_wdata = '0; cap_be = '0; cap_we = 1'b0; cap_code = '0;
  endtask

  // One instruction: request cycle, BUSY cycles, DONE, then an idle cycle.
  task automatic txn(input logic we, input logic [1:0] size, input logic sext,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int ack_at, input int rst_at, input bit flush_busy);
    bit finished;
    next_cycle();
    mem_valid = 1'b1; mem_we = we; mem_size = size; mem_sext = sext;
    addr = a; wdata = wd; flush = 1'b0; bus_ack = 1'b0;
    set_idle();
    if (!m_aligned(size, a)) begin
      e_exc  = 1'b1;
      e_code = we ? 5'd5 : 5'd4;
      next_cycle();
      mem_valid = 1'b0;
      set_idle();
      return;
    end
    e_stall = 1'b1;
    finished = 1'b0;
    for (int k = 1; k <= int'(TO) && !finished; k++) begin
      next_cycle();
      set_idle();
      e_stall = 1'b1; e_req = 1'b1; e_we = we;
      e_addr = {a[31:2], 2'b00}; e_be = m_be(size, a); e_wdata = m_wdata(size, wd);
      flush = flush_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      addr = $urandom;
      bus_rdata = (k == ack_at) ? rd : $urandom;
      bus_ack = (k == ack_at) && (k != rst_at);
      if (k == rst_at) begin
        reset = 1'b0;
        next_cycle();
        reset = 1'b1; mem_valid = 1'b0; bus_ack = 1'b0; flush = 1'b0;
        m_dr = '0;
        set_idle();
        return;
      end
      if (k == ack_at) begin
        next_cycle();
        bus_ack = 1'b0; flush = 1'b0;
        if (!we) m_dr = m_load(rd, a, size, sext);
        set_idle();
        e_done = 1'b1;
        finished = 1'b1;
      end
    end
    if (!finished) begin
      next_cycle();
      bus_ack = 1'b0; flush = 1'b0;
      m_dr = '0;
      set_idle();
      e_done = 1'b1; e_exc = 1'b1; e_code = 5'd7;
    end
    next_cycle();
    mem_valid = 1'b0;
    set_idle();
  endtask

  task automatic idle_flush(input logic we, input logic [1:0] size, input logic [31:0] a);
    next_cycle();
    mem_valid = 1'b1; mem_we = we; mem_size = size; addr = a; flush = 1'b1;
    set_idle();
    next_cycle();
    mem_valid = 1'b0; flush = 1'b0;
    set_idle();
  endtask

  initial begin
    reset = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_sext = 1'b0;
    addr = '0; wdata = '0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    m_dr = '0;
    clear_caps();
    next_cycle();
    set_idle();
    ev = 1'b1;
    next_cycle();
    reset = 1'b1;
    set_idle();

    // Word load, ack on second BUSY cycle.
    clear_caps();
    txn(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0, 32'hDEADBEEF, 2, 0, 1'b0);
    chk("word_load_dr", DR_out, 32'hDEADBEEF);
    chk("word_load_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("word_load_done_pulses", 32'(done_cnt), 32'd1);
    chk("word_load_be", 32'(cap_be), 32'hF);

    // Signed and unsigned byte loads from lane 3.
    clear_caps();
    txn(1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 32'h80112233, 1, 0, 1'b0);
    chk("sbyte_dr", DR_out, 32'hFFFFFF80);
    chk("sbyte_be", 32'(cap_be), 32'h8);
    txn(1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0, 32'h80112233, 3, 0, 1'b0);
    chk("ubyte_dr", DR_out, 32'h00000080);

    // Half store to upper half.
    clear_caps();
    txn(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000ABCD, 32'h0, 1, 0, 1'b0);
    chk("hstore_we", 32'(cap_we), 32'd1);
    chk("hstore_be", 32'(cap_be), 32'hC);
    chk("hstore_wdata", cap_wdata, 32'hABCDABCD);
    chk("hstore_keeps_dr", DR_out, 32'h00000080);

    // Misaligned word load and store.
    clear_caps();
    txn(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 32'h0, 1, 0, 1'b0);
    chk("adel_code", 32'(cap_code), 32'd4);
    chk("adel_no_req", 32'(req_cnt), 32'd0);
    chk("adel_no_stall", 32'(stall_cnt), 32'd0);
    txn(1'b1, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 32'h0, 1, 0, 1'b0);
    chk("ades_code", 32'(cap_code), 32'd5);

    // Flush in IDLE: neither request nor exception.
    clear_caps();
    idle_flush(1'b0, 2'b10, 32'h0000_5001);
    idle_flush(1'b1, 2'b10, 32'h0000_5000);
    chk("idle_flush_no_req", 32'(req_cnt), 32'd0);

    // Timeout, then ack on the last allowed cycle.
    clear_caps();
    txn(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 32'h12345678, 0, 0, 1'b0);
    chk("timeout_dr", DR_out, 32'h0);
    chk("timeout_code", 32'(cap_code), 32'd7);
    chk("timeout_stall_cycles", 32'(stall_cnt), 32'd17);
    txn(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 32'h12345678, 16, 0, 1'b0);
    chk("late_ack_dr", DR_out, 32'h12345678);

    // Reset in the second BUSY cycle, then flush during BUSY.
    clear_caps();
    txn(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0, 32'hCAFEF00D, 5, 2, 1'b0);
    chk("reset_busy_dr", DR_out, 32'h0);
    chk("reset_busy_no_done", 32'(done_cnt), 32'd0);
    txn(1'b0, 2'b01, 1'b1, 32'h0000_7002, 32'h0, 32'h9ABC0000, 3, 0, 1'b1);
    chk("flush_busy_dr", DR_out, 32'hFFFF9ABC);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ra;
      int r, ack, rst;
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      r = int'($urandom_range(0, 9));
      rst = 0;
      if (r < 6) ack = int'($urandom_range(1, 4));
      else if (r == 6) ack = int'(TO);
      else if (r == 7) ack = 0;
      else if (r == 8) ack = int'($urandom_range(5, 15));
      else begin
        rst = int'($urandom_range(1, 3));
        ack = rst + 1;
      end
      if ($urandom_range(0, 15) == 0) idle_flush(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra);
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ra, $urandom, $urandom, ack, rst, 1'($urandom_range(0, 1)));
    end

    next_cycle();
    ev = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the bus cycles waited for bus_ack before a bus error is raised.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port mem_valid  input  1  M-stage instruction is a load or store.
REQ-005 SHALL have port mem_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port mem_size  input  2  access size: 00 byte, 01 half, 10 word; 11 is reserved and treated as word.
REQ-007 SHALL have port mem_sext  input  1  sign-extend load data.
REQ-008 SHALL have port addr  input  32  byte address (AO of M stage).
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port flush  input  1  exception/eret flush of M stage.
REQ-011 SHALL have port bus_req, bus_we  output  1 each  bus request and write strobe.
REQ-012 SHALL have port bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-013 SHALL have port bus_be  output  4  byte enables.
REQ-014 SHALL have port bus_wdata  output  32  lane-replicated store data.
REQ-015 SHALL have port bus_ack  input  1  transfer complete; bus_rdata is valid in the same cycle.
REQ-016 SHALL have port bus_rdata  input  32  read word.
REQ-017 SHALL have port stall  output  1  freezes PC through M stage.
REQ-018 SHALL have port DR_out  output  32  extended load data, consumed by the W pipeline register.
REQ-019 SHALL have port exc, exc_code  output  1 and 5  exception flag and cause: 4 AdEL, 5 AdES, 7 DBE.
REQ-020 SHALL have port done  output  1  one-cycle pulse marking access completion.

Function
REQ-021 SHALL implement the FSM states IDLE, BUSY, DONE.
REQ-022 SHALL define aligned as: byte always; half requires addr[0]=0; word requires addr[1:0]=0.
REQ-023 IDLE: when mem_valid && aligned && !flush, the FSM SHALL latch request fields and go to BUSY next edge; stall SHALL be 1 combinationally in that cycle.
REQ-024 IDLE misaligned: exc SHALL be 1 combinationally with code 4 for a load or 5 for a store; no bus request SHALL be made; stall SHALL be 0.
REQ-025 IDLE with flush=1: no request SHALL be started and no exception SHALL be raised.
REQ-026 BUSY: bus_req SHALL be 1, bus outputs SHALL be driven from latched fields, and stall SHALL be 1.
REQ-027 BUSY: flush SHALL be ignored so that the transaction completes.
REQ-028 BUSY with bus_ack=1: DR_out SHALL be registered and the FSM SHALL go to DONE.
REQ-029 DONE: done SHALL be 1, stall SHALL be 0, and the FSM SHALL return to IDLE unconditionally; mem_valid seen in DONE belongs to the same instruction and SHALL be ignored.
REQ-030 BUSY timeout: a counter SHALL count BUSY cycles; if TIMEOUT cycles pass without bus_ack, the FSM SHALL go to DONE with registered exc=1, code 7, and DR_out=0.
REQ-031 The counter SHALL clear on BUSY entry.
REQ-032 bus_ack arriving in the same cycle that the counter reaches TIMEOUT-1 SHALL be treated as success.
REQ-033 Byte enables SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-034 bus_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-035 Load extraction SHALL select the lane by addr[1:0], then zero-extend, or sign-extend when mem_sext=1.
REQ-036 Stores SHALL leave DR_out unchanged.
REQ-037 Outside IDLE-misaligned and DONE-timeout, exc SHALL be 0.

Reset
REQ-038 reset=0 at a clock edge SHALL force state IDLE, counter 0, DR_out 0, latched fields 0, and registered exc 0.
REQ-039 Reset mid-BUSY SHALL drop bus_req at that edge; the transaction SHALL be abandoned.
REQ-040 Combinational outputs SHALL follow state after reset: stall=0, done=0, bus_req=0.

Structure
REQ-041 A shared package SHALL hold: size encodings, exc codes (4/5/7), the state enum, and the TIMEOUT default.
REQ-042 Sub-module load_ext SHALL hold the combinational lane select and extension (inputs rdata, addr[1:0], size, sext; output 32-bit data).

Verification
REQ-043 Word load, addr=0x0000_1004, ack after 2 BUSY cycles with rdata=0xDEADBEEF -> stall high for 3 cycles, done pulse, DR_out=0xDEADBEEF, bus_be=1111.
REQ-044 Signed byte load, addr=0x...03, rdata=0x80112233 -> bus_be=1000, DR_out=0xFFFFFF80; with mem_sext=0 -> DR_out=0x00000080.
REQ-045 Half store, addr=0x...02, wdata=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD.
REQ-046 Word load at addr=0x...02 -> exc=1, exc_code=4, no bus_req, stall=0; same as a store -> exc_code=5.
REQ-047 No ack for 16 BUSY cycles -> DONE with exc=1, exc_code=7, DR_out=0; repeat with ack on the 16th cycle -> success.
REQ-048 reset=0 in the second BUSY cycle -> bus_req=0 next cycle, state IDLE, DR_out=0; flush asserted in BUSY -> transfer still completes.
